// File: rtl/ext_pkg.sv
// Shared types for the immediate/operand extension unit: mode encoding and its width.
package ext_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    EXT_SEXT  = 3'b000,
    EXT_ZEXT  = 3'b001,
    EXT_UPPER = 3'b010,
    EXT_BOFF  = 3'b011,
    EXT_LB    = 3'b100,
    EXT_LBU   = 3'b101,
    EXT_LH    = 3'b110,
    EXT_LHU   = 3'b111
  } ext_mode_t;

endpackage

// File: rtl/ext_core.sv
// Combinational mode -> extended result. Load extraction exists only under EXT_LOAD_EN;
// without it, load modes yield zero.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [IN_W-1:0]   imm,
`ifdef EXT_LOAD_EN
  input  logic [31:0]       ld_data,
  input  logic [1:0]        ld_off,
`endif
  output logic [OUT_W-1:0]  result
);

  logic [OUT_W-1:0] sext;
`ifdef EXT_LOAD_EN
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
`endif

  always_comb begin
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
`ifdef EXT_LOAD_EN
    ld_shift = ld_data >> {ld_off, 3'b000};
    ld_byte  = ld_shift[7:0];
    // Halfword alignment faults are detected elsewhere; off[0] is ignored here.
    ld_half  = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
`endif
    result = '0;
    case (ext_mode_t'(mode))
      EXT_SEXT:  result = sext;
      EXT_ZEXT:  result = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_UPPER: result = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BOFF:  result = sext << 2;
`ifdef EXT_LOAD_EN
      EXT_LB:    result = {{(OUT_W-8){ld_byte[7]}}, ld_byte};
      EXT_LBU:   result = {{(OUT_W-8){1'b0}}, ld_byte};
      EXT_LH:    result = {{(OUT_W-16){ld_half[15]}}, ld_half};
      EXT_LHU:   result = {{(OUT_W-16){1'b0}}, ld_half};
`endif
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/extend_pipe.sv
// Pipelined immediate/operand extender with a main register plus one-entry skid buffer.
// Optional load-data extension is enabled by defining EXT_LOAD_EN.
module extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [IN_W-1:0]   in_imm,
`ifdef EXT_LOAD_EN
  input  logic [31:0]       in_ld_data,
  input  logic [1:0]        in_ld_off,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  logic [OUT_W-1:0] ext_res;
  logic             main_vld_q, main_vld_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             accept, drain;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .mode    (in_mode),
    .imm     (in_imm),
`ifdef EXT_LOAD_EN
    .ld_data (in_ld_data),
    .ld_off  (in_ld_off),
`endif
    .result  (ext_res)
  );

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_vld_q && out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (drain) begin
      main_vld_d = skid_vld_q;
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end
    end
    // accept implies skid empty, so a draining main can always take the new result.
    if (accept) begin
      if (!main_vld_q || drain) begin
        main_vld_d  = 1'b1;
        main_data_d = ext_res;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = ext_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe (IN_W=16, OUT_W=32); load modes checked when EXT_LOAD_EN is set.
module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_imm;
  logic [31:0] ld_data;
  logic [1:0]  ld_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic [31:0] q[$];
  logic [31:0] pend_exp;
  logic        acc;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_imm     (in_imm),
`ifdef EXT_LOAD_EN
    .in_ld_data (ld_data),
    .in_ld_off  (ld_off),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] imm,
                                        input logic [31:0] ld, input logic [1:0] off);
    logic [31:0] s, b, h;
    s = 32'($signed(imm));
    b = (ld >> (8 * off)) & 32'hFF;
    h = off[1] ? (ld >> 16) : (ld & 32'hFFFF);
    case (m)
      3'd0: return s;
      3'd1: return {16'h0, imm};
      3'd2: return {imm, 16'h0};
      3'd3: return s * 4;
`ifdef EXT_LOAD_EN
      3'd4: return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd5: return b;
      3'd6: return h[15] ? (h | 32'hFFFF0000) : h;
      default: return h;
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scores the handshakes of the current cycle, then advances to just after the next edge.
  task automatic step();
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_output", out_data, 32'hDEADBEEF ^ out_data);
      else chk("scoreboard", out_data, q.pop_front());
    end
    acc = !rst && in_valid && in_ready;
    if (acc) q.push_back(pend_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [15:0] imm,
                       input logic [31:0] ld, input logic [1:0] off, input logic [31:0] exp);
    in_valid = 1'b1; in_mode = m; in_imm = imm; ld_data = ld; ld_off = off; pend_exp = exp;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; acc = 1'b0;
    drive(3'd0, 16'h1111, 32'h0, 2'd0, 32'h00001111);
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("rst_no_output", {31'b0, out_valid}, 32'h0);

    // Back-to-back streaming, one result per cycle with 1-cycle latency.
    drive(3'd0, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001); step();
    chk("lat_sext", {31'b0, out_valid}, 32'h1);
    drive(3'd1, 16'h8001, 32'h0, 2'd0, 32'h00008001); step();
    chk("lat_zext", {31'b0, out_valid}, 32'h1);
    drive(3'd2, 16'h1234, 32'h0, 2'd0, 32'h12340000); step();
    chk("lat_upper", {31'b0, out_valid}, 32'h1);
    drive(3'd3, 16'hFFFF, 32'h0, 2'd0, 32'hFFFFFFFC); step();
    chk("lat_boff", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0; step();
    chk("stream_empty", {31'b0, out_valid}, 32'h0);

`ifdef EXT_LOAD_EN
    drive(3'd4, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF); step();
    drive(3'd5, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080); step();
    drive(3'd6, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01); step();
    drive(3'd7, 16'h0, 32'h80FF7F01, 2'd2, 32'h000080FF); step();
`else
    drive(3'd4, 16'hABCD, 32'h0, 2'd0, 32'h0); step();
    chk("noload_lat", {31'b0, out_valid}, 32'h1);
    chk("noload_zero", out_data, 32'h0);
    drive(3'd7, 16'hFFFF, 32'h0, 2'd0, 32'h0); step();
`endif
    in_valid = 1'b0; step(); step();

    // Backpressure: main then skid fill, third operand held off.
    out_ready = 1'b0;
    drive(3'd0, 16'h0001, 32'h0, 2'd0, 32'h1); step();
    chk("bp_ready_after1", {31'b0, in_ready}, 32'h1);
    drive(3'd0, 16'h0002, 32'h0, 2'd0, 32'h2); step();
    chk("bp_ready_after2", {31'b0, in_ready}, 32'h0);
    drive(3'd0, 16'h0003, 32'h0, 2'd0, 32'h3); step();
    chk("bp_third_held", {31'b0, acc}, 32'h0);
    chk("bp_hold_data", out_data, 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_drained", q.size(), 32'h0);
    chk("bp_ready_back", {31'b0, in_ready}, 32'h1);

    // Reset while main and skid are both occupied.
    out_ready = 1'b0;
    drive(3'd1, 16'h00AA, 32'h0, 2'd0, 32'h000000AA); step();
    drive(3'd1, 16'h00BB, 32'h0, 2'd0, 32'h000000BB); step();
    in_valid = 1'b0;
    chk("mid_skid_full", {31'b0, in_ready}, 32'h0);
    rst = 1'b1; step(); rst = 1'b0;
    q.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    step(); step(); step();

    // Random mix with random backpressure against the reference model.
    for (int i = 0; i < 60; i++) begin
      if (!in_valid || acc) begin
        logic [2:0] m; logic [15:0] imm; logic [31:0] ld; logic [1:0] off;
        m = 3'($urandom_range(0, 7)); imm = 16'($urandom); ld = $urandom; off = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) drive(m, imm, ld, off, model(m, imm, ld, off));
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("final_drained", q.size(), 32'h0);
    chk("final_idle", {31'b0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
